lift_scheduler: RTL and testbench
=================================

# lift_scheduler

Request-side controller for the 7-floor elevator. It latches car and hall calls, tracks the car position from the Lift block's `nextFloor`/`move` outputs, and drives Lift's `currentFloor`, `currentDirection` and `doorState` inputs using collective (same-direction-first) scheduling. It sits between the button/panel logic and Lift, closing the loop Lift opens.

## Interface
- `DOOR_CLK`, 10000000: cycles `doorState` stays ON per stop (≥1).
- `clk` input 1: system clock, all logic on posedge.
- `reset` input 1: synchronous, active-high; priority over everything.
- `enable` input 1: when 0, state machine, floor tracking and door timer freeze; call latching continues.
- `carCall` input 7: bit i = car button for floor i+1, one-cycle or level.
- `upCall` input 7: hall UP, bit i = floor i+1; bit 6 ignored.
- `downCall` input 7: hall DOWN; bit 0 ignored.
- `nextFloor` input 3: from Lift; the floor being travelled to while `move`=1.
- `move` input 1: from Lift; 1 while travelling between floors.
- `currentFloor` output 3: registered car floor, 1..7.
- `currentDirection` output 2: STOP=00, UP=10, DOWN=01; UPDOWN (11) never driven.
- `doorState` output 1: 1 while door open.
- `pendingCalls` output 7: OR of latched car/up/down calls, for panel lamps.

## Operation
- Reset: `currentFloor`=1, `currentDirection`=STOP, `doorState`=0, all pending registers 0, state IDLE, preferred direction UP, door counter 0.
- Latching: pending bit set on the edge a request bit is sampled 1; cleared only by a stop (below). Press on a bit being cleared in the same cycle: cleared wins.
- Floor tracking: while `move`=1 register `arrival`←`nextFloor`; on `move` 1→0 (registered previous value), `currentFloor`←`arrival`.
- Let above/below = any pending bit strictly above/below `currentFloor`.
- IDLE: `currentDirection`=STOP. If any call at `currentFloor` → DOOR (clear that floor's car/up/down bits). Else if preferred UP and above → UP, MOVE; else if below → DOWN, MOVE (preferred←DOWN); else if above → UP, MOVE (preferred←UP); else stay.
- MOVE: hold direction until `move` falls. On arrival floor f going UP: stop if carCall[f] or upCall[f] or no calls above f; clear car/up bits at f, and down bit too if no calls above f. DOWN symmetric. Stop → `currentDirection`=STOP, DOOR. No stop → keep direction, remain MOVE.
- DOOR: `doorState`=1, counter loaded DOOR_CLK−1, decrements; at 0 → `doorState`=0, IDLE. New calls at `currentFloor` during DOOR are cleared (absorbed).
- Never drive UP at floor 7 or DOWN at floor 1; never drive non-STOP while `doorState`=1.

## Timing
- Request sampled edge n → pending visible edge n → direction/door output registered edge n+1.
- Arrival: `move` low sampled edge m → `currentFloor` and STOP/door decision both registered edge m+1.
- `doorState` high exactly DOOR_CLK enabled cycles; IDLE re-evaluation on following edge.
- `enable`=0 stalls counter and state; `doorState`/`currentDirection` hold value.
- Reset mid-MOVE/DOOR: all outputs to reset values next edge; pending calls lost.

## Configuration
- `LIFT_SCHED_DOOR_REOPEN_EN` defined: car or hall call at `currentFloor` during DOOR reloads counter to DOOR_CLK−1 (door held longer), call still absorbed. Undefined: call absorbed, timer unaffected.

## Structure
- `elevator_pkg`: direction codes STOP/UP/DOWN/UPDOWN, F_FST=1, F_TOP=7, ON/OFF, scheduler state enum {IDLE, MOVE, DOOR}.
- Sub-module `call_latch`: three 7-bit pending registers with set/clear-floor interface and above/below/at-floor reductions; scheduler FSM, floor tracker and door timer stay in top.

## Test plan
- Reset then idle: `currentFloor`=1, STOP, `doorState`=0, `pendingCalls`=0 for 20 cycles.
- carCall=7'b0010000 (floor 5) at floor 1, Lift model responding → UP; arrivals 2,3,4 no stop; at 5 STOP, `doorState`=1 for DOOR_CLK=4 cycles, bit cleared.
- At floor 3 going UP with upCall floor 4 and downCall floor 2 pending → stops at 4, then reverses, stops at 2; never UPDOWN.
- upCall at current floor during DOOR → absorbed, door closes after 4 cycles (macro off) / 4 cycles after the press (macro on).
- `enable`=0 for 10 cycles mid-DOOR → door counter frozen; calls pressed meanwhile appear on `pendingCalls`.
- Reset asserted mid-MOVE at floor 4 → next edge floor 1, STOP, all pending cleared.

Source files
------------

// File: rtl/lift_scheduler_pkg.sv
// Shared types and floor helpers for the lift request scheduler.
package elevator_pkg;
    localparam int NFLOORS = 7;
    localparam logic [2:0] F_FST = 3'd1;
    localparam logic [2:0] F_TOP = 3'd7;
    localparam logic ON  = 1'b1;
    localparam logic OFF = 1'b0;

    typedef enum logic [1:0] {STOP = 2'b00, DOWN = 2'b01, UP = 2'b10, UPDOWN = 2'b11} dir_e;
    typedef enum logic [1:0] {IDLE, MOVE, DOOR} sched_state_e;
    typedef logic [NFLOORS-1:0] floor_vec_t;

    // There is no UP button on the top floor and no DOWN button on the ground floor.
    localparam floor_vec_t UP_VALID = 7'b0111111;
    localparam floor_vec_t DN_VALID = 7'b1111110;

    function automatic floor_vec_t floor_bit(input logic [2:0] f);
        floor_vec_t v = '0;
        for (int i = 0; i < int'(F_TOP); i++) v[i] = (i + 1 == int'(f));
        return v;
    endfunction

    function automatic floor_vec_t above_mask(input logic [2:0] f);
        floor_vec_t v = '0;
        for (int i = 0; i < int'(F_TOP); i++) v[i] = (i + 1 > int'(f));
        return v;
    endfunction

    function automatic floor_vec_t below_mask(input logic [2:0] f);
        floor_vec_t v = '0;
        for (int i = 0; i < int'(F_TOP); i++) v[i] = (i + 1 < int'(f));
        return v;
    endfunction
endpackage

// File: rtl/lift_scheduler_if.sv
// Panel/Lift-side signal bundle of the scheduler; master = environment, slave = scheduler.
interface lift_scheduler_if;
    import elevator_pkg::*;
    logic       enable;
    floor_vec_t carCall;
    floor_vec_t upCall;
    floor_vec_t downCall;
    logic [2:0] nextFloor;
    logic       move;
    logic [2:0] currentFloor;
    logic [1:0] currentDirection;
    logic       doorState;
    floor_vec_t pendingCalls;

    modport master (
        output enable, carCall, upCall, downCall, nextFloor, move,
        input  currentFloor, currentDirection, doorState, pendingCalls
    );
    modport slave (
        input  enable, carCall, upCall, downCall, nextFloor, move,
        output currentFloor, currentDirection, doorState, pendingCalls
    );
endinterface

// File: rtl/lift_scheduler_call_latch.sv
// Pending car/up/down call registers with floor-clear port and above/below/at-floor queries.
module call_latch
    import elevator_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  floor_vec_t car_i,
    input  floor_vec_t up_i,
    input  floor_vec_t dn_i,
    input  logic [2:0] clr_floor_i,
    input  logic       clr_car_i,
    input  logic       clr_up_i,
    input  logic       clr_dn_i,
    input  logic [2:0] qfloor_i,
    output floor_vec_t pending_o,
    output logic       above_o,
    output logic       below_o,
    output logic       at_car_o,
    output logic       at_up_o,
    output logic       at_dn_o
);
    floor_vec_t car_q, car_d, up_q, up_d, dn_q, dn_d;
    floor_vec_t clr_m, q_m;

    // A press landing on a floor being cleared is dropped: clear wins.
    always_comb begin
        clr_m = floor_bit(clr_floor_i);
        car_d = (car_q | car_i) & ~({NFLOORS{clr_car_i}} & clr_m);
        up_d  = (up_q | (up_i & UP_VALID)) & ~({NFLOORS{clr_up_i}} & clr_m);
        dn_d  = (dn_q | (dn_i & DN_VALID)) & ~({NFLOORS{clr_dn_i}} & clr_m);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            car_q <= '0;
            up_q  <= '0;
            dn_q  <= '0;
        end else begin
            car_q <= car_d;
            up_q  <= up_d;
            dn_q  <= dn_d;
        end
    end

    assign q_m       = floor_bit(qfloor_i);
    assign pending_o = car_q | up_q | dn_q;
    assign above_o   = |(pending_o & above_mask(qfloor_i));
    assign below_o   = |(pending_o & below_mask(qfloor_i));
    assign at_car_o  = |(car_q & q_m);
    assign at_up_o   = |(up_q & q_m);
    assign at_dn_o   = |(dn_q & q_m);
endmodule

// File: rtl/lift_scheduler.sv
// Collective (same-direction-first) scheduler closing the loop around Lift.
// Build option: LIFT_SCHED_DOOR_REOPEN_EN re-arms the door timer on calls at the open floor.
module lift_scheduler
    import elevator_pkg::*;
#(
    parameter int DOOR_CLK = 10000000
) (
    input logic             clk,
    input logic             reset,
    lift_scheduler_if.slave bus
);
    localparam int CW = (DOOR_CLK > 1) ? $clog2(DOOR_CLK) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(DOOR_CLK - 1);

    sched_state_e  state_q, state_d;
    dir_e          dir_q, dir_d;
    logic          door_q, door_d, pref_up_q, pref_up_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    floor_q, floor_d, arrival_q, arrival_d, qfloor;
    logic          move_q, move_prev_q, arrived;
    logic          above, below, at_car, at_up, at_dn, at_any, stop, reload;
    logic          clr_car, clr_up, clr_dn;

    // While travelling, stop decisions are taken against the floor just reached.
    assign arrived = move_prev_q & ~move_q;
    assign qfloor  = (state_q == MOVE) ? arrival_q : floor_q;
    assign at_any  = at_car | at_up | at_dn;
    assign stop    = (dir_q == UP) ? (at_car | at_up | ~above) : (at_car | at_dn | ~below);

`ifdef LIFT_SCHED_DOOR_REOPEN_EN
    assign reload = (state_q == DOOR) &&
        |((bus.carCall | (bus.upCall & UP_VALID) | (bus.downCall & DN_VALID)) & floor_bit(floor_q));
`else
    assign reload = 1'b0;
`endif

    call_latch u_calls (
        .clk        (clk),
        .reset      (reset),
        .car_i      (bus.carCall),
        .up_i       (bus.upCall),
        .dn_i       (bus.downCall),
        .clr_floor_i(qfloor),
        .clr_car_i  (clr_car),
        .clr_up_i   (clr_up),
        .clr_dn_i   (clr_dn),
        .qfloor_i   (qfloor),
        .pending_o  (bus.pendingCalls),
        .above_o    (above),
        .below_o    (below),
        .at_car_o   (at_car),
        .at_up_o    (at_up),
        .at_dn_o    (at_dn)
    );

    always_comb begin : track
        floor_d   = floor_q;
        arrival_d = arrival_q;
        if (bus.move) arrival_d = bus.nextFloor;
        if (arrived)  floor_d   = arrival_q;
    end

    always_comb begin : next_state
        state_d = state_q;
        case (state_q)
            IDLE:    if (at_any) state_d = DOOR;
                     else if (above || below) state_d = MOVE;
            MOVE:    if (arrived && stop) state_d = DOOR;
            DOOR:    if (cnt_q == '0 && !reload) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin : outputs
        dir_d     = dir_q;
        door_d    = door_q;
        cnt_d     = cnt_q;
        pref_up_d = pref_up_q;
        clr_car   = 1'b0;
        clr_up    = 1'b0;
        clr_dn    = 1'b0;
        case (state_q)
            IDLE: begin
                dir_d = STOP;
                if (at_any) begin
                    door_d  = ON;
                    cnt_d   = CNT_LOAD;
                    clr_car = 1'b1;
                    clr_up  = 1'b1;
                    clr_dn  = 1'b1;
                end else if (pref_up_q && above) begin
                    dir_d = UP;
                end else if (below) begin
                    dir_d     = DOWN;
                    pref_up_d = 1'b0;
                end else if (above) begin
                    dir_d     = UP;
                    pref_up_d = 1'b1;
                end
            end
            MOVE: begin
                // Opposite-direction hall call is only served here when nothing lies beyond.
                if (arrived && stop) begin
                    dir_d   = STOP;
                    door_d  = ON;
                    cnt_d   = CNT_LOAD;
                    clr_car = 1'b1;
                    clr_up  = (dir_q == UP) ? 1'b1 : ~below;
                    clr_dn  = (dir_q == UP) ? ~above : 1'b1;
                end
            end
            DOOR: begin
                clr_car = 1'b1;
                clr_up  = 1'b1;
                clr_dn  = 1'b1;
                if (reload)              cnt_d  = CNT_LOAD;
                else if (cnt_q == '0)    door_d = OFF;
                else                     cnt_d  = cnt_q - 1'b1;
            end
            default: dir_d = STOP;
        endcase
        if (!bus.enable) begin
            clr_car = 1'b0;
            clr_up  = 1'b0;
            clr_dn  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin : state_reg
        if (reset)           state_q <= IDLE;
        else if (bus.enable) state_q <= state_d;
    end

    always_ff @(posedge clk) begin : regs
        if (reset) begin
            dir_q       <= STOP;
            door_q      <= OFF;
            cnt_q       <= '0;
            pref_up_q   <= 1'b1;
            floor_q     <= F_FST;
            arrival_q   <= F_FST;
            move_q      <= 1'b0;
            move_prev_q <= 1'b0;
        end else if (bus.enable) begin
            dir_q       <= dir_d;
            door_q      <= door_d;
            cnt_q       <= cnt_d;
            pref_up_q   <= pref_up_d;
            floor_q     <= floor_d;
            arrival_q   <= arrival_d;
            move_q      <= bus.move;
            move_prev_q <= move_q;
        end
    end

    assign bus.currentFloor     = floor_q;
    assign bus.currentDirection = dir_q;
    assign bus.doorState        = door_q;
endmodule

// File: tb/tb_lift_scheduler.sv
// Bench for lift_scheduler: Lift travel model, stop-floor scoreboard, per-scenario tasks.
`timescale 1ns/1ps
module tb_lift_scheduler;
    import elevator_pkg::*;
    localparam int DCLK = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    lift_scheduler_if ifc();
    lift_scheduler #(.DOOR_CLK(DCLK)) dut (.clk(clk), .reset(reset), .bus(ifc));

    int n_vec = 0;
    int n_err = 0;
    int sb[$];
    logic [2:0] lift_pos;
    logic door_prev;
    logic aborted;

    // Lift model: one floor per trip, 3 cycles travel, then waits for the scheduler's decision.
    initial begin
        ifc.move = 1'b0;
        ifc.nextFloor = 3'd1;
        lift_pos = 3'd1;
        forever begin
            @(posedge clk); #1;
            if (reset) begin
                lift_pos = 3'd1;
            end else if (ifc.doorState == 1'b0 &&
                         (ifc.currentDirection == 2'b10 || ifc.currentDirection == 2'b01)) begin
                ifc.nextFloor = (ifc.currentDirection == 2'b10) ? lift_pos + 3'd1 : lift_pos - 3'd1;
                ifc.move = 1'b1;
                aborted = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(posedge clk); #1;
                    if (reset) begin aborted = 1'b1; break; end
                end
                ifc.move = 1'b0;
                if (aborted) lift_pos = 3'd1;
                else begin
                    lift_pos = ifc.nextFloor;
                    repeat (3) @(posedge clk);
                end
            end
        end
    end

    // Monitor: output invariants every cycle, and each door opening against the expected stop.
    initial begin
        int exp_f;
        door_prev = 1'b0;
        forever begin
            @(negedge clk);
            n_vec++;
            if (ifc.currentDirection === 2'b11 ||
                (ifc.doorState === 1'b1 && ifc.currentDirection !== 2'b00) ||
                (ifc.currentFloor === 3'd7 && ifc.currentDirection === 2'b10) ||
                (ifc.currentFloor === 3'd1 && ifc.currentDirection === 2'b01)) begin
                n_err++;
                $display("FAIL invariant: floor=%0d dir=%b door=%b, required legal direction",
                         ifc.currentFloor, ifc.currentDirection, ifc.doorState);
            end
            if (ifc.doorState === 1'b1 && door_prev !== 1'b1) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL stop_floor: stopped at %0d, required no stop", ifc.currentFloor);
                end else begin
                    exp_f = sb.pop_front();
                    if (int'(ifc.currentFloor) !== exp_f) begin
                        n_err++;
                        $display("FAIL stop_floor: got %0d, required %0d", ifc.currentFloor, exp_f);
                    end
                end
            end
            door_prev = ifc.doorState;
        end
    end

    task automatic press(input logic [6:0] c, input logic [6:0] u, input logic [6:0] d);
        @(posedge clk); #1;
        ifc.carCall = c; ifc.upCall = u; ifc.downCall = d;
        @(posedge clk); #1;
        ifc.carCall = '0; ifc.upCall = '0; ifc.downCall = '0;
    endtask

    task automatic wait_door(input string tag);
        int t = 0;
        @(negedge clk);
        while (ifc.doorState !== 1'b1 && t < 400) begin @(negedge clk); t++; end
        n_vec++;
        if (ifc.doorState !== 1'b1) begin
            n_err++;
            $display("FAIL %s_timeout: door=%b after %0d cycles, required 1", tag, ifc.doorState, t);
        end
    endtask

    task automatic count_door(output int n);
        n = 0;
        while (ifc.doorState === 1'b1 && n < 100) begin n++; @(negedge clk); end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ifc.enable = 1'b1;
        ifc.carCall = '0; ifc.upCall = '0; ifc.downCall = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_vec++;
            if ({ifc.currentFloor, ifc.currentDirection, ifc.doorState, ifc.pendingCalls} !==
                {3'd1, 2'b00, 1'b0, 7'b0}) begin
                n_err++;
                $display("FAIL reset_idle: floor=%0d dir=%b door=%b pend=%b, required 1/00/0/0",
                         ifc.currentFloor, ifc.currentDirection, ifc.doorState, ifc.pendingCalls);
            end
        end
        // Top-floor UP and ground-floor DOWN buttons do not exist.
        press(7'b0, 7'b1000000, 7'b0000001);
        @(negedge clk);
        n_vec++;
        if (ifc.pendingCalls !== 7'b0) begin
            n_err++;
            $display("FAIL ignored_bits: pend=%b, required 0000000", ifc.pendingCalls);
        end
        repeat (5) @(negedge clk);
        n_vec++;
        if (ifc.doorState !== 1'b0 || ifc.currentDirection !== 2'b00) begin
            n_err++;
            $display("FAIL ignored_bits_idle: door=%b dir=%b, required 0/00", ifc.doorState, ifc.currentDirection);
        end
    endtask

    task automatic test_car_call();
        int n;
        sb.push_back(5);
        press(7'b0010000, 7'b0, 7'b0);
        @(negedge clk);
        n_vec++;
        if (ifc.pendingCalls !== 7'b0010000) begin
            n_err++;
            $display("FAIL car_pending: pend=%b, required 0010000", ifc.pendingCalls);
        end
        @(negedge clk);
        n_vec++;
        if (ifc.currentDirection !== 2'b10) begin
            n_err++;
            $display("FAIL car_dir: dir=%b, required 10", ifc.currentDirection);
        end
        wait_door("car");
        count_door(n);
        n_vec++;
        if (n !== DCLK) begin
            n_err++;
            $display("FAIL car_door_len: %0d cycles, required %0d", n, DCLK);
        end
        n_vec++;
        if (ifc.pendingCalls !== 7'b0 || ifc.currentFloor !== 3'd5) begin
            n_err++;
            $display("FAIL car_after: pend=%b floor=%0d, required 0000000/5", ifc.pendingCalls, ifc.currentFloor);
        end
    endtask

    task automatic test_reverse();
        int n;
        sb.push_back(1);
        press(7'b0000001, 7'b0, 7'b0);
        wait_door("rev_home");
        count_door(n);
        sb.push_back(4);
        sb.push_back(2);
        press(7'b0, 7'b0001000, 7'b0000010);
        @(negedge clk);
        n_vec++;
        if (ifc.pendingCalls !== 7'b0001010) begin
            n_err++;
            $display("FAIL rev_pending: pend=%b, required 0001010", ifc.pendingCalls);
        end
        wait_door("rev_up");
        count_door(n);
        n_vec++;
        if (ifc.pendingCalls !== 7'b0000010) begin
            n_err++;
            $display("FAIL rev_after4: pend=%b, required 0000010", ifc.pendingCalls);
        end
        wait_door("rev_down");
        count_door(n);
        n_vec++;
        if (n !== DCLK || ifc.pendingCalls !== 7'b0 || ifc.currentFloor !== 3'd2) begin
            n_err++;
            $display("FAIL rev_after2: len=%0d pend=%b floor=%0d, required %0d/0000000/2",
                     n, ifc.pendingCalls, ifc.currentFloor, DCLK);
        end
    endtask

    task automatic test_absorb();
        int n, exp_n;
`ifdef LIFT_SCHED_DOOR_REOPEN_EN
        exp_n = DCLK;
`else
        exp_n = DCLK - 2;
`endif
        sb.push_back(2);
        press(7'b0000010, 7'b0, 7'b0);
        wait_door("absorb");
        @(posedge clk); #1;
        ifc.upCall = 7'b0000010;
        @(posedge clk); #1;
        ifc.upCall = 7'b0;
        @(negedge clk);
        n_vec++;
        if (ifc.pendingCalls !== 7'b0) begin
            n_err++;
            $display("FAIL absorb_pending: pend=%b, required 0000000", ifc.pendingCalls);
        end
        count_door(n);
        n_vec++;
        if (n !== exp_n) begin
            n_err++;
            $display("FAIL absorb_door_rest: %0d cycles after press, required %0d", n, exp_n);
        end
    endtask

    task automatic test_enable_stall();
        int n;
        sb.push_back(2);
        press(7'b0000010, 7'b0, 7'b0);
        wait_door("stall");
        ifc.enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 1) begin ifc.carCall = 7'b0100000; ifc.downCall = 7'b0000100; end
            if (i == 2) begin ifc.carCall = 7'b0; ifc.downCall = 7'b0; end
            n_vec++;
            if (ifc.doorState !== 1'b1 || ifc.currentDirection !== 2'b00) begin
                n_err++;
                $display("FAIL stall_hold[%0d]: door=%b dir=%b, required 1/00", i, ifc.doorState, ifc.currentDirection);
            end
        end
        n_vec++;
        if (ifc.pendingCalls !== 7'b0100100) begin
            n_err++;
            $display("FAIL stall_pending: pend=%b, required 0100100", ifc.pendingCalls);
        end
        sb.push_back(6);
        sb.push_back(3);
        ifc.enable = 1'b1;
        count_door(n);
        n_vec++;
        if (n !== DCLK) begin
            n_err++;
            $display("FAIL stall_door_rest: %0d cycles after resume, required %0d", n, DCLK);
        end
        wait_door("stall_up");
        count_door(n);
        wait_door("stall_down");
        count_door(n);
        n_vec++;
        if (ifc.pendingCalls !== 7'b0 || ifc.currentFloor !== 3'd3) begin
            n_err++;
            $display("FAIL stall_after: pend=%b floor=%0d, required 0000000/3", ifc.pendingCalls, ifc.currentFloor);
        end
    endtask

    task automatic test_reset_mid_move();
        int t = 0;
        press(7'b1000000, 7'b0, 7'b0);
        @(negedge clk);
        while (!(ifc.currentFloor === 3'd4 && ifc.move === 1'b1) && t < 400) begin @(negedge clk); t++; end
        n_vec++;
        if (!(ifc.currentFloor === 3'd4 && ifc.move === 1'b1)) begin
            n_err++;
            $display("FAIL midmove_timeout: floor=%0d move=%b, required 4/1", ifc.currentFloor, ifc.move);
        end
        reset = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({ifc.currentFloor, ifc.currentDirection, ifc.doorState, ifc.pendingCalls} !==
            {3'd1, 2'b00, 1'b0, 7'b0}) begin
            n_err++;
            $display("FAIL midmove_reset: floor=%0d dir=%b door=%b pend=%b, required 1/00/0/0",
                     ifc.currentFloor, ifc.currentDirection, ifc.doorState, ifc.pendingCalls);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        n_vec++;
        if ({ifc.currentFloor, ifc.currentDirection, ifc.pendingCalls} !== {3'd1, 2'b00, 7'b0}) begin
            n_err++;
            $display("FAIL midmove_settle: floor=%0d dir=%b pend=%b, required 1/00/0",
                     ifc.currentFloor, ifc.currentDirection, ifc.pendingCalls);
        end
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL stops_outstanding: %0d expected stops never seen, required 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_car_call();
        test_reverse();
        test_absorb();
        test_enable_stall();
        test_reset_mid_move();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
